// File: rtl/uart_rx_deser_hs_pkg.sv
// Shared types and constants for the UART RX deserializer.
package uart_rx_pkg;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    localparam int DATA_W_DEF      = 8;
    localparam int SAMPLE_EDGE_DEF = 6;

    // Counter must be able to hold the value DATA_W.
    function automatic int bitcnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/uart_rx_deser_hs_if.sv
// Output word handshake between the deserializer (master) and its consumer (slave).
interface uart_rx_deser_hs_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              data_ready;
    logic              overrun;
    logic              par_calc;

    modport master (
        output P_DATA, data_valid, overrun, par_calc,
        input  data_ready
    );

    modport slave (
        input  P_DATA, data_valid, overrun, par_calc,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_deser_hs_shift_reg.sv
// DATA_W serial-in shift register; LSB_FIRST picks which end the new bit enters.
module uart_rx_shift_reg
    import uart_rx_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] shifted_o
);
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    // shifted_o already includes the incoming bit so completion can load it directly.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign shifted_o = {bit_i, sr_q[DATA_W-1:1]};
        end else begin : g_msb
            assign shifted_o = {sr_q[DATA_W-2:0], bit_i};
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (shift_en_i) begin
            sr_d = shifted_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end
endmodule

// File: rtl/uart_rx_deser_hs.sv
// UART RX deserializer with valid/ready output register and sticky overrun.
// Optional macro UART_RX_PARITY_CALC_EN adds registered even parity of P_DATA.
module uart_rx_deser_hs
    import uart_rx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int EDGE_W      = 3,
    parameter int SAMPLE_EDGE = SAMPLE_EDGE_DEF,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic                         clk,
    input  logic                         RST,
    input  logic                         deser_en,
    input  logic                         sampled_bit,
    input  logic [EDGE_W-1:0]            edge_cnt,
    input  logic                         clr,
    output logic [bitcnt_w(DATA_W)-1:0]  bit_cnt,
    uart_rx_deser_hs_if.master           dout
);
    localparam int CNT_W = bitcnt_w(DATA_W);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stb, shift_en, done;
    logic [DATA_W-1:0] shifted;

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    assign stb = deser_en && (edge_cnt == EDGE_W'(SAMPLE_EDGE));

    uart_rx_shift_reg #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_sr (
        .clk        (clk),
        .rst        (RST),
        .clr_i      (clr),
        .shift_en_i (shift_en),
        .bit_i      (sampled_bit),
        .shifted_o  (shifted)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        done     = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (stb) begin
            shift_en = 1'b1;
            unique case (state_q)
                IDLE: begin
                    cnt_d   = CNT_W'(1);
                    state_d = COLLECT;
                end
                COLLECT: begin
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A completing word is only dropped when the old one is still unconsumed.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && dout.data_ready) begin
            valid_d = 1'b0;
        end
        if (done) begin
            if (!valid_q || dout.data_ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_CALC_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            par_q <= 1'b0;
        end else if (done && (!valid_q || dout.data_ready)) begin
            par_q <= ^shifted;
        end
    end

    assign dout.par_calc = par_q;
`else
    assign dout.par_calc = 1'b0;
`endif

    assign bit_cnt         = cnt_q;
    assign dout.P_DATA     = data_q;
    assign dout.data_valid = valid_q;
    assign dout.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_deser_hs.sv
// Directed bench for uart_rx_deser_hs: LSB-first and MSB-first instances share stimulus
// and are checked every cycle against a queue-based frame model plus literal expectations.
module tb_uart_rx_deser_hs;
    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       deser_en = 1'b0;
    logic       sampled_bit = 1'b0;
    logic [2:0] edge_cnt = 3'd0;
    logic       clr = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] cnt_l, cnt_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_deser_hs_if #(.DATA_W(8)) if_l ();
    uart_rx_deser_hs_if #(.DATA_W(8)) if_m ();
    assign if_l.data_ready = ready;
    assign if_m.data_ready = ready;

    uart_rx_deser_hs #(.DATA_W(8), .EDGE_W(3), .SAMPLE_EDGE(6), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .RST(RST), .deser_en(deser_en), .sampled_bit(sampled_bit),
        .edge_cnt(edge_cnt), .clr(clr), .bit_cnt(cnt_l), .dout(if_l));

    uart_rx_deser_hs #(.DATA_W(8), .EDGE_W(3), .SAMPLE_EDGE(6), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .RST(RST), .deser_en(deser_en), .sampled_bit(sampled_bit),
        .edge_cnt(edge_cnt), .clr(clr), .bit_cnt(cnt_m), .dout(if_m));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: received bits queue up; eight of them form a word.
    // Index 0 = LSB-first instance, index 1 = MSB-first instance.
    bit         m_bits[$];
    logic [7:0] m_data[2];
    logic       m_valid[2];
    logic       m_ovr[2];
    logic       m_par[2];
    logic [7:0] m_word[2];
    bit         m_done;
    bit         m_init = 1'b0;

    always @(posedge clk) begin
        if (RST) begin
            m_init = 1'b1;
            m_bits.delete();
            for (int k = 0; k < 2; k++) begin
                m_data[k] = 8'h00; m_valid[k] = 1'b0; m_ovr[k] = 1'b0; m_par[k] = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (clr) begin
                m_bits.delete();
            end else if (deser_en && edge_cnt == 3'd6) begin
                m_bits.push_back(sampled_bit);
                if (m_bits.size() == 8) begin
                    m_done = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        m_word[0][i]     = m_bits[i];
                        m_word[1][7 - i] = m_bits[i];
                    end
                    m_bits.delete();
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (m_done && (!m_valid[k] || ready)) begin
                    m_data[k]  = m_word[k];
                    m_valid[k] = 1'b1;
`ifdef UART_RX_PARITY_CALC_EN
                    m_par[k] = ^m_word[k];
`else
                    m_par[k] = 1'b0;
`endif
                end else begin
                    if (m_done) m_ovr[k] = 1'b1;
                    if (m_valid[k] && ready) m_valid[k] = 1'b0;
                end
                if (clr) m_ovr[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("cnt_l",   32'(cnt_l),           32'(m_bits.size()));
            chk("cnt_m",   32'(cnt_m),           32'(m_bits.size()));
            chk("data_l",  32'(if_l.P_DATA),     32'(m_data[0]));
            chk("data_m",  32'(if_m.P_DATA),     32'(m_data[1]));
            chk("valid_l", 32'(if_l.data_valid), 32'(m_valid[0]));
            chk("valid_m", 32'(if_m.data_valid), 32'(m_valid[1]));
            chk("ovr_l",   32'(if_l.overrun),    32'(m_ovr[0]));
            chk("ovr_m",   32'(if_m.overrun),    32'(m_ovr[1]));
            chk("par_l",   32'(if_l.par_calc),   32'(m_par[0]));
            chk("par_m",   32'(if_m.par_calc),   32'(m_par[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bit = one full edge_cnt sweep 0..7; the strobe is the edge_cnt==6 cycle.
    task automatic send_bit(input logic b, input bit pulse_ready);
        sampled_bit = b;
        for (int e = 0; e < 8; e++) begin
            edge_cnt = 3'(e);
            if (pulse_ready) ready = (e == 6);
            step();
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input bit pulse_last);
        for (int i = 0; i < 8; i++) send_bit(w[i], pulse_last && (i == 7));
    endtask

    initial begin
        logic exp_par7;
`ifdef UART_RX_PARITY_CALC_EN
        exp_par7 = 1'b1;
`else
        exp_par7 = 1'b0;
`endif
        step(); step();
        chk("rst_data", 32'(if_l.P_DATA), 32'h0);
        chk("rst_cnt",  32'(cnt_l), 32'h0);
        RST = 1'b0;
        deser_en = 1'b1;

        // Basic frames, both bit orders
        ready = 1'b1;
        send_frame(8'hA5, 1'b0);
        chk("a5_l", 32'(if_l.P_DATA), 32'hA5);
        chk("a5_m", 32'(if_m.P_DATA), 32'hA5);
        send_frame(8'h3C, 1'b0);
        chk("3c_l", 32'(if_l.P_DATA), 32'h3C);
        chk("3c_m", 32'(if_m.P_DATA), 32'h3C);
        send_frame(8'h01, 1'b0);
        chk("01_l", 32'(if_l.P_DATA), 32'h01);
        chk("01_m", 32'(if_m.P_DATA), 32'h80);
        chk("01_ovr", 32'(if_l.overrun), 32'h0);

        // Overrun with consumer stalled, then clr keeps the held word
        ready = 1'b0;
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        chk("ovr_data", 32'(if_l.P_DATA), 32'h11);
        chk("ovr_set",  32'(if_l.overrun), 32'h1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_ovr",   32'(if_l.overrun), 32'h0);
        chk("clr_data",  32'(if_l.P_DATA), 32'h11);
        chk("clr_valid", 32'(if_l.data_valid), 32'h1);

        // Ready only in the completion cycle: reload without overrun
        send_frame(8'h55, 1'b1);
        chk("rl_valid", 32'(if_l.data_valid), 32'h1);
        chk("rl_data_l", 32'(if_l.P_DATA), 32'h55);
        chk("rl_data_m", 32'(if_m.P_DATA), 32'hAA);
        chk("rl_ovr", 32'(if_l.overrun), 32'h0);
        ready = 1'b1; step();

        // clr mid-frame, then a clean frame
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        clr = 1'b1; step(); clr = 1'b0;
        chk("abort_cnt", 32'(cnt_l), 32'h0);
        send_frame(8'h0F, 1'b0);
        chk("0f_l", 32'(if_l.P_DATA), 32'h0F);
        chk("0f_m", 32'(if_m.P_DATA), 32'hF0);

        // RST mid-frame
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        chk("pre_rst_cnt", 32'(cnt_l), 32'h5);
        RST = 1'b1; step(); RST = 1'b0;
        chk("rst2_cnt",   32'(cnt_l), 32'h0);
        chk("rst2_data",  32'(if_l.P_DATA), 32'h0);
        chk("rst2_valid", 32'(if_l.data_valid), 32'h0);
        chk("rst2_ovr",   32'(if_l.overrun), 32'h0);

        // Parity
        send_frame(8'h07, 1'b0);
        chk("par07", 32'(if_l.par_calc), 32'(exp_par7));
        send_frame(8'h03, 1'b0);
        chk("par03", 32'(if_l.par_calc), 32'h0);

        // deser_en low mid-frame holds progress
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        deser_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            edge_cnt = 3'(i % 8);
            step();
        end
        chk("hold_cnt", 32'(cnt_l), 32'h3);
        deser_en = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        chk("hold_data", 32'(if_l.P_DATA), 32'hF8);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
